text_box_ctrl: RTL and testbench
================================

# text_box_ctrl

Typewriter-style dialogue box controller that sequences and feeds the 8x8 font glyph renderer (`font_sprites`). It accepts character codes through a valid/ready handshake and reveals them one at a time at a frame-paced rate into a COLS x ROWS character buffer. It waits for a player advance press when the box is full, then clears. On the render side it tracks `hcount_in`/`vcount_in` and drives the renderer's glyph position and sheet-select inputs for the cell under the beam.

## Interface
- COLS, 16, characters per row
- ROWS, 2, text rows
- BOX_X, 64, left pixel of box (must be >= 2)
- BOX_Y, 600, top line of box
- CELL_H, 16, row pitch in lines (power of two, >= 8)
- CHAR_DELAY, 2, frames between revealed characters (0 = one per cycle)
- GLYPH_PITCH, 9, glyph pitch in font sheet, both axes
- SHEET_COLS, 16, glyphs per sheet row (power of two)
- pixel_clk_in  in  1  pixel clock, sole clock
- rst_in  in  1  asynchronous, active-high reset
- hcount_in  in  11  current beam x
- vcount_in  in  10  current beam y
- char_in  in  7  character code
- char_valid_in  in  1  char_in valid
- char_ready_out  out  1  controller accepts char this cycle
- advance_in  in  1  one-cycle advance pulse (debounced A button)
- more_out  out  1  box full, waiting for advance
- glyph_x_out  out  11  to renderer x_in
- glyph_y_out  out  10  to renderer y_in
- sprite_sel_x_out  out  10  to renderer sprite_sel_x
- sprite_sel_y_out  out  9  to renderer sprite_sel_y

## Operation
- States: CLEAR, TYPE, WAIT_ADV. Reset enters CLEAR.
- CLEAR:
  - Writes CHAR_SPACE to one buffer cell per cycle, addresses 0..COLS*ROWS-1.
  - Zeroes the cursor and sets the frame counter to CHAR_DELAY.
  - Moves to TYPE after the last cell is written.
- Frame tick: a single-cycle pulse when hcount_in==0 and vcount_in==0. The frame counter increments on each tick and saturates at CHAR_DELAY.
- TYPE:
  - char_ready_out = 1 iff the frame counter >= CHAR_DELAY.
  - On valid&&ready with a printable code: write the code at the cursor, increment the cursor, and zero the frame counter.
  - CHAR_NEWLINE (0x0A): no write; the cursor advances to the next row start and the frame counter zeroes.
  - When the cursor reaches COLS*ROWS (including via a newline on the last row), move to WAIT_ADV.
- WAIT_ADV:
  - more_out=1 and char_ready_out=0.
  - An advance_in pulse moves to CLEAR. advance_in is ignored in every other state.
- Render path:
  - col=(hcount_in+2-BOX_X)>>3 and row=(vcount_in-BOX_Y)>>log2(CELL_H).
  - The cell is in-box when col<COLS, row<ROWS, and both differences are non-negative.
  - In-box outputs:
    - glyph_x_out=BOX_X+col*8 and glyph_y_out=BOX_Y+row*CELL_H.
    - sprite_sel_x_out=(code%SHEET_COLS)*GLYPH_PITCH and sprite_sel_y_out=(code/SHEET_COLS)*GLYPH_PITCH.
  - Out of box: glyph_x_out=2000 (never matches any hcount) and all other render outputs are 0.
- Buffer writes and render reads are independent ports. A written cell is visible from the next read. A partially cleared box mid-frame is acceptable.

## Timing
- Render pipeline: 2 cycles, with a 2-pixel lookahead.
  - Stage 1 registers the cell address and the in-box flag.
  - Stage 2 registers the outputs from the synchronous buffer read.
  - As a result, outputs are correct for the pixel currently on hcount_in, and adjacent cells tile with no glitch pixel.
- char_ready_out is combinational from state and the counter. Acceptance takes effect on the same edge, so ready drops the following cycle when CHAR_DELAY>0.
- CLEAR lasts exactly COLS*ROWS cycles.
- advance_in coinciding with the final character's acceptance is ignored, because the controller is still in TYPE.
- Reset values: char_ready_out 0, more_out 0, glyph_x_out 2000, all other outputs 0. Buffer contents are undefined until CLEAR completes.
- Reset asserted mid-operation aborts immediately and re-runs CLEAR.

## Configuration
- TEXT_MORE_ARROW_EN defined: in WAIT_ADV, the bottom-right cell renders MORE_GLYPH (overriding its buffer content) on frames where a 5-bit frame counter's MSB is 1, giving a 32-frame blink.
- TEXT_MORE_ARROW_EN undefined: no override; only more_out signals the full box.

## Structure
- text_box_pkg: state enum, CHAR_SPACE (0x00), CHAR_NEWLINE (0x0A), MORE_GLYPH (0x7F), OFFSCREEN_X (2000).
- Sub-module text_char_buf: COLS*ROWS x 7-bit register array with one write port and one synchronous read port.

## Test plan
- Reset, then 32 cycles: buffer all CHAR_SPACE, state TYPE, char_ready_out=1 because the counter is preset.
- CHAR_DELAY=2, stream "HI": H accepted immediately, I accepted exactly 2 frame ticks later, cells 0 and 1 = 0x48 and 0x49.
- 0x48 in cell 0: at hcount=64..71 and vcount=600, glyph_x_out=64, sprite_sel_x_out=72, sprite_sel_y_out=36. At hcount=72, glyph_x_out=72.
- 5 chars, 0x0A, 1 char: the last char lands in cell 16. A 0x0A on row 1 forces WAIT_ADV with more_out=1 and char_ready_out=0.
- In WAIT_ADV, pulse advance_in: 32 CLEAR cycles, then TYPE with an empty cursor. advance_in pulsed during TYPE has no effect.
- Assert rst_in mid-CLEAR at cycle 10: outputs return to reset values on the same edge, and a full 32-cycle CLEAR follows deassertion.

Source files
------------

// File: rtl/text_box_pkg.sv
// Shared constants for the dialogue box controller: FSM state encodings,
// special character codes and the off-screen glyph position.
package text_box_pkg;

    localparam logic [1:0] ST_CLEAR    = 2'd0;
    localparam logic [1:0] ST_TYPE     = 2'd1;
    localparam logic [1:0] ST_WAIT_ADV = 2'd2;

    localparam logic [6:0] CHAR_SPACE   = 7'h00;
    localparam logic [6:0] CHAR_NEWLINE = 7'h0A;
    localparam logic [6:0] MORE_GLYPH   = 7'h7F;

    // Far right of any raster line, so the renderer never matches it.
    localparam logic [10:0] OFFSCREEN_X = 11'd2000;

endpackage

// File: rtl/text_char_buf.sv
// Character buffer: one write port and one registered read port.
// A write is visible to reads issued on the following cycle.
module text_char_buf #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [6:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [6:0]    rd_data
);

    logic [6:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/text_box_ctrl.sv
// Typewriter dialogue box: reveals characters into a COLS x ROWS buffer and
// drives the glyph renderer. Define TEXT_MORE_ARROW_EN for the blinking arrow.
module text_box_ctrl
    import text_box_pkg::*;
#(
    parameter int COLS        = 16,
    parameter int ROWS        = 2,
    parameter int BOX_X       = 64,
    parameter int BOX_Y       = 600,
    parameter int CELL_H      = 16,
    parameter int CHAR_DELAY  = 2,
    parameter int GLYPH_PITCH = 9,
    parameter int SHEET_COLS  = 16
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [6:0]  char_in,
    input  logic        char_valid_in,
    output logic        char_ready_out,
    input  logic        advance_in,
    output logic        more_out,
    output logic [10:0] glyph_x_out,
    output logic [9:0]  glyph_y_out,
    output logic [9:0]  sprite_sel_x_out,
    output logic [8:0]  sprite_sel_y_out,
    output logic [1:0]  state_out
);

    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);
    localparam int CW    = $clog2(CELLS + 1);
    localparam int FW    = $clog2(CHAR_DELAY + 2);
    localparam int RSH   = $clog2(CELL_H);

    localparam logic [FW-1:0] DELAY     = FW'(CHAR_DELAY);
    localparam logic [CW-1:0] CELLS_C   = CW'(CELLS);
    localparam logic [CW-1:0] COLS_C    = CW'(COLS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);

    logic [1:0]    state;
    logic [AW-1:0] clr_addr;
    logic [CW-1:0] cursor;
    logic [CW-1:0] cur_col;
    logic [FW-1:0] fcnt;

    logic          frame_tick;
    logic          accept;
    logic          is_nl;
    logic [CW-1:0] next_cursor;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [6:0]    wr_data;

    assign frame_tick = (hcount_in == 11'd0) && (vcount_in == 10'd0);

    // Handshake: a character transfers on any cycle where char_valid_in and
    // char_ready_out are both high; ready never depends on valid.
    assign char_ready_out = (state == ST_TYPE) && (fcnt >= DELAY);
    assign accept         = char_valid_in && char_ready_out;
    assign is_nl          = (char_in == CHAR_NEWLINE);
    assign next_cursor    = is_nl ? (cursor + (COLS_C - cur_col)) : (cursor + CW'(1));
    assign more_out       = (state == ST_WAIT_ADV);
    assign state_out      = state;

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
            cursor   <= '0;
            cur_col  <= '0;
            fcnt     <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    cursor   <= '0;
                    cur_col  <= '0;
                    fcnt     <= DELAY;
                    clr_addr <= clr_addr + AW'(1);
                    if (clr_addr == LAST_ADDR) begin
                        clr_addr <= '0;
                        state    <= ST_TYPE;
                    end
                end
                ST_TYPE: begin
                    if (accept) begin
                        fcnt    <= '0;
                        cursor  <= next_cursor;
                        cur_col <= (is_nl || cur_col == COLS_C - CW'(1)) ? '0 : cur_col + CW'(1);
                        if (next_cursor == CELLS_C) begin
                            state <= ST_WAIT_ADV;
                        end
                    end else if (frame_tick && fcnt < DELAY) begin
                        fcnt <= fcnt + FW'(1);
                    end
                end
                ST_WAIT_ADV: begin
                    if (advance_in) begin
                        clr_addr <= '0;
                        state    <= ST_CLEAR;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = cursor[AW-1:0];
        wr_data = char_in;
        if (state == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
            wr_data = CHAR_SPACE;
        end else if (accept && !is_nl) begin
            wr_en = 1'b1;
        end
    end

    // Render: look two pixels ahead so the two register stages land on time.
    logic [12:0]   dx, dy, col_w, row_w;
    logic          in_box;
    logic          s1_in_box, s2_in_box;
    logic [AW-1:0] s1_addr;
    logic [10:0]   s1_gx;
    logic [9:0]    s1_gy;
    logic [6:0]    rd_data;
    logic [6:0]    code;

    assign dx     = {2'b00, hcount_in} + 13'd2 - 13'(BOX_X);
    assign dy     = {3'b000, vcount_in} - 13'(BOX_Y);
    assign col_w  = dx >> 3;
    assign row_w  = dy >> RSH;
    assign in_box = !dx[12] && !dy[12] && (col_w < 13'(COLS)) && (row_w < 13'(ROWS));

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1_in_box   <= 1'b0;
            s1_addr     <= '0;
            s1_gx       <= '0;
            s1_gy       <= '0;
            s2_in_box   <= 1'b0;
            glyph_x_out <= OFFSCREEN_X;
            glyph_y_out <= '0;
        end else begin
            s1_in_box   <= in_box;
            s1_addr     <= AW'(int'(row_w) * COLS + int'(col_w));
            s1_gx       <= 11'(BOX_X + int'(col_w) * 8);
            s1_gy       <= 10'(BOX_Y + int'(row_w) * CELL_H);
            s2_in_box   <= s1_in_box;
            glyph_x_out <= s1_in_box ? s1_gx : OFFSCREEN_X;
            glyph_y_out <= s1_in_box ? s1_gy : '0;
        end
    end

    text_char_buf #(
        .DEPTH (CELLS),
        .AW    (AW)
    ) u_buf (
        .clk     (pixel_clk_in),
        .rst     (rst_in),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (s1_addr),
        .rd_data (rd_data)
    );

`ifdef TEXT_MORE_ARROW_EN
    logic [4:0] blink;
    logic       s1_arrow, s2_arrow;

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            blink    <= '0;
            s1_arrow <= 1'b0;
            s2_arrow <= 1'b0;
        end else begin
            if (frame_tick) begin
                blink <= blink + 5'd1;
            end
            s1_arrow <= (state == ST_WAIT_ADV) && blink[4] &&
                        (AW'(int'(row_w) * COLS + int'(col_w)) == LAST_ADDR);
            s2_arrow <= s1_arrow;
        end
    end

    assign code = s2_arrow ? MORE_GLYPH : rd_data;
`else
    assign code = rd_data;
`endif

    assign sprite_sel_x_out = s2_in_box ? 10'((int'(code) % SHEET_COLS) * GLYPH_PITCH) : '0;
    assign sprite_sel_y_out = s2_in_box ? 9'((int'(code) / SHEET_COLS) * GLYPH_PITCH) : '0;

endmodule

// File: tb/tb_text_box_ctrl.sv
// Directed bench for text_box_ctrl: reset, typing pace, render path,
// newline/full box, advance and reset during clear.
module tb_text_box_ctrl;
    import text_box_pkg::*;

    logic        pixel_clk_in = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [6:0]  char_in;
    logic        char_valid_in;
    logic        char_ready_out;
    logic        advance_in;
    logic        more_out;
    logic [10:0] glyph_x_out;
    logic [9:0]  glyph_y_out;
    logic [9:0]  sprite_sel_x_out;
    logic [8:0]  sprite_sel_y_out;
    logic [1:0]  state_out;

    int n_vec = 0;
    int n_err = 0;
    logic [6:0] cells [32];
    int cur;

    text_box_ctrl dut (
        .pixel_clk_in     (pixel_clk_in),
        .rst_in           (rst_in),
        .hcount_in        (hcount_in),
        .vcount_in        (vcount_in),
        .char_in          (char_in),
        .char_valid_in    (char_valid_in),
        .char_ready_out   (char_ready_out),
        .advance_in       (advance_in),
        .more_out         (more_out),
        .glyph_x_out      (glyph_x_out),
        .glyph_y_out      (glyph_y_out),
        .sprite_sel_x_out (sprite_sel_x_out),
        .sprite_sel_y_out (sprite_sel_y_out),
        .state_out        (state_out)
    );

    always #5 pixel_clk_in = ~pixel_clk_in;

    task automatic step();
        @(posedge pixel_clk_in);
        #1;
    endtask

    task automatic tick();
        hcount_in = 11'd0;
        vcount_in = 10'd0;
        step();
        hcount_in = 11'd100;
        vcount_in = 10'd100;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) cells[i] = 7'h00;
        cur = 0;
    endtask

    task automatic send_char(input logic [6:0] c);
        for (int i = 0; i < 8 && !char_ready_out; i++) tick();
        n_vec++;
        if (char_ready_out !== 1'b1) begin
            $display("FAIL send_ready: ready=%b want 1 (char %h)", char_ready_out, c);
            n_err++;
        end
        char_in       = c;
        char_valid_in = 1'b1;
        step();
        char_valid_in = 1'b0;
        if (c == 7'h0A) begin
            cur = (cur / 16 + 1) * 16;
        end else begin
            cells[cur] = c;
            cur++;
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        step(); step(); step();
        n_vec += 5;
        if (char_ready_out !== 1'b0) begin $display("FAIL rst_ready: got %b want 0", char_ready_out); n_err++; end
        if (more_out !== 1'b0) begin $display("FAIL rst_more: got %b want 0", more_out); n_err++; end
        if (glyph_x_out !== 11'd2000) begin $display("FAIL rst_gx: got %0d want 2000", glyph_x_out); n_err++; end
        if (glyph_y_out !== 10'd0) begin $display("FAIL rst_gy: got %0d want 0", glyph_y_out); n_err++; end
        if (sprite_sel_x_out !== 10'd0 || sprite_sel_y_out !== 9'd0) begin
            $display("FAIL rst_sel: got %0d/%0d want 0/0", sprite_sel_x_out, sprite_sel_y_out); n_err++;
        end
        rst_in = 1'b0;
        for (int i = 0; i < 31; i++) step();
        n_vec += 2;
        if (state_out !== 2'd0) begin $display("FAIL clear_len_state: got %0d want 0", state_out); n_err++; end
        if (char_ready_out !== 1'b0) begin $display("FAIL clear_len_ready: got %b want 0", char_ready_out); n_err++; end
        step();
        n_vec += 2;
        if (state_out !== 2'd1) begin $display("FAIL after_clear_state: got %0d want 1", state_out); n_err++; end
        if (char_ready_out !== 1'b1) begin $display("FAIL after_clear_ready: got %b want 1", char_ready_out); n_err++; end
        model_clear();
    endtask

    task automatic test_type_hi();
        n_vec++;
        if (char_ready_out !== 1'b1) begin $display("FAIL h_ready: got %b want 1", char_ready_out); n_err++; end
        char_in = 7'h48; char_valid_in = 1'b1;
        step();
        cells[0] = 7'h48; cur = 1;
        char_in = 7'h49;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (char_ready_out !== 1'b0) begin $display("FAIL i_wait0: got %b want 0", char_ready_out); n_err++; end
            step();
        end
        char_valid_in = 1'b0;
        tick();
        n_vec++;
        if (char_ready_out !== 1'b0) begin $display("FAIL i_wait1: got %b want 0", char_ready_out); n_err++; end
        tick();
        n_vec++;
        if (char_ready_out !== 1'b1) begin $display("FAIL i_ready2: got %b want 1", char_ready_out); n_err++; end
        char_valid_in = 1'b1;
        step();
        char_valid_in = 1'b0;
        cells[1] = 7'h49; cur = 2;
        n_vec++;
        if (char_ready_out !== 1'b0) begin $display("FAIL i_accepted: got %b want 0", char_ready_out); n_err++; end
    endtask

    task automatic test_render(input int v, input int h0, input int h1);
        int col, row, code, ex_gx, ex_gy, ex_sx, ex_sy;
        vcount_in = 10'(v);
        for (int h = h0; h <= h1; h++) begin
            hcount_in = 11'(h);
            if (h >= h0 + 2) begin
                if (h >= 64 && h < 192 && v >= 600 && v < 632) begin
                    col   = (h - 64) / 8;
                    row   = (v - 600) / 16;
                    code  = int'(cells[row * 16 + col]);
                    ex_gx = 64 + col * 8;
                    ex_gy = 600 + row * 16;
                    ex_sx = (code % 16) * 9;
                    ex_sy = (code / 16) * 9;
                end else begin
                    ex_gx = 2000; ex_gy = 0; ex_sx = 0; ex_sy = 0;
                end
                n_vec += 4;
                if (glyph_x_out !== 11'(ex_gx)) begin
                    $display("FAIL gx h=%0d v=%0d: got %0d want %0d", h, v, glyph_x_out, ex_gx); n_err++;
                end
                if (glyph_y_out !== 10'(ex_gy)) begin
                    $display("FAIL gy h=%0d v=%0d: got %0d want %0d", h, v, glyph_y_out, ex_gy); n_err++;
                end
                if (sprite_sel_x_out !== 10'(ex_sx)) begin
                    $display("FAIL selx h=%0d v=%0d: got %0d want %0d", h, v, sprite_sel_x_out, ex_sx); n_err++;
                end
                if (sprite_sel_y_out !== 9'(ex_sy)) begin
                    $display("FAIL sely h=%0d v=%0d: got %0d want %0d", h, v, sprite_sel_y_out, ex_sy); n_err++;
                end
            end
            step();
        end
        hcount_in = 11'd100;
        vcount_in = 10'd100;
    endtask

    task automatic test_newline_full();
        for (int i = 0; i < 5; i++) send_char(7'(8'h41 + i));
        send_char(7'h0A);
        send_char(7'h5A);
        n_vec += 2;
        if (state_out !== 2'd1) begin $display("FAIL row1_state: got %0d want 1", state_out); n_err++; end
        if (more_out !== 1'b0) begin $display("FAIL row1_more: got %b want 0", more_out); n_err++; end
        send_char(7'h0A);
        n_vec += 3;
        if (state_out !== 2'd2) begin $display("FAIL full_state: got %0d want 2", state_out); n_err++; end
        if (more_out !== 1'b1) begin $display("FAIL full_more: got %b want 1", more_out); n_err++; end
        if (char_ready_out !== 1'b0) begin $display("FAIL full_ready: got %b want 0", char_ready_out); n_err++; end
        for (int i = 0; i < 3; i++) tick();
        n_vec++;
        if (char_ready_out !== 1'b0) begin $display("FAIL full_ready_ticks: got %b want 0", char_ready_out); n_err++; end
        test_render(616, 56, 110);
        test_render(600, 56, 120);
    endtask

    task automatic test_advance();
        advance_in = 1'b1;
        step();
        advance_in = 1'b0;
        n_vec += 3;
        if (state_out !== 2'd0) begin $display("FAIL adv_state: got %0d want 0", state_out); n_err++; end
        if (more_out !== 1'b0) begin $display("FAIL adv_more: got %b want 0", more_out); n_err++; end
        if (char_ready_out !== 1'b0) begin $display("FAIL adv_ready: got %b want 0", char_ready_out); n_err++; end
        for (int i = 0; i < 31; i++) step();
        n_vec++;
        if (state_out !== 2'd0) begin $display("FAIL adv_clear_len: got %0d want 0", state_out); n_err++; end
        step();
        n_vec += 2;
        if (state_out !== 2'd1) begin $display("FAIL adv_type: got %0d want 1", state_out); n_err++; end
        if (char_ready_out !== 1'b1) begin $display("FAIL adv_type_ready: got %b want 1", char_ready_out); n_err++; end
        model_clear();
        advance_in = 1'b1;
        step();
        advance_in = 1'b0;
        n_vec += 2;
        if (state_out !== 2'd1) begin $display("FAIL adv_in_type: got %0d want 1", state_out); n_err++; end
        if (more_out !== 1'b0) begin $display("FAIL adv_in_type_more: got %b want 0", more_out); n_err++; end
        send_char(7'h41);
        test_render(600, 56, 130);
        test_render(616, 56, 80);
    endtask

    task automatic test_reset_mid_clear();
        send_char(7'h0A);
        send_char(7'h0A);
        n_vec++;
        if (state_out !== 2'd2) begin $display("FAIL pre_clear_state: got %0d want 2", state_out); n_err++; end
        vcount_in  = 10'd600;
        hcount_in  = 11'd70;
        advance_in = 1'b1;
        step();
        advance_in = 1'b0;
        for (int i = 0; i < 9; i++) step();
        n_vec += 2;
        if (state_out !== 2'd0) begin $display("FAIL mid_clear_state: got %0d want 0", state_out); n_err++; end
        if (glyph_x_out !== 11'd72) begin $display("FAIL mid_clear_gx: got %0d want 72", glyph_x_out); n_err++; end
        #2;
        rst_in = 1'b1;
        #1;
        n_vec += 4;
        if (glyph_x_out !== 11'd2000) begin $display("FAIL async_rst_gx: got %0d want 2000", glyph_x_out); n_err++; end
        if (glyph_y_out !== 10'd0) begin $display("FAIL async_rst_gy: got %0d want 0", glyph_y_out); n_err++; end
        if (state_out !== 2'd0) begin $display("FAIL async_rst_state: got %0d want 0", state_out); n_err++; end
        if (char_ready_out !== 1'b0) begin $display("FAIL async_rst_ready: got %b want 0", char_ready_out); n_err++; end
        step();
        rst_in    = 1'b0;
        hcount_in = 11'd100;
        vcount_in = 10'd100;
        for (int i = 0; i < 31; i++) step();
        n_vec++;
        if (state_out !== 2'd0) begin $display("FAIL rerun_clear_len: got %0d want 0", state_out); n_err++; end
        step();
        n_vec += 2;
        if (state_out !== 2'd1) begin $display("FAIL rerun_type: got %0d want 1", state_out); n_err++; end
        if (char_ready_out !== 1'b1) begin $display("FAIL rerun_ready: got %b want 1", char_ready_out); n_err++; end
        model_clear();
        test_render(600, 56, 200);
    endtask

    initial begin
        rst_in        = 1'b1;
        hcount_in     = 11'd100;
        vcount_in     = 10'd100;
        char_in       = 7'h00;
        char_valid_in = 1'b0;
        advance_in    = 1'b0;
        model_clear();
        test_reset();
        test_render(600, 56, 200);
        test_type_hi();
        test_render(600, 56, 200);
        test_render(599, 60, 80);
        test_render(632, 60, 80);
        test_newline_full();
        test_advance();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
